ifetch_unit: RTL and testbench
==============================

IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 Parameters SHALL be, one per line:
- PC_W, 8, program counter and instruction address width.
- INSTR_W, 8, instruction width, equal to the control unit IR width.
- RESET_PC, 0, PC value after reset.

REQ-002 Ports SHALL be, one per line:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- fetch_req  in  1  control-word bit requesting a fetch at the current PC.
- pc_load  in  1  control-word bit loading PC from pc_load_val.
- pc_load_val  in  PC_W  branch/jump target.
- imem_req  out  1  instruction-memory request.
- imem_addr  out  PC_W  instruction-memory address.
- imem_ack  in  1  memory response-valid strobe.
- imem_data  in  INSTR_W  memory read data; valid when imem_ack=1.
- IR  out  INSTR_W  instruction register, feeds the control unit MAP stage.
- ir_valid  out  1  one-cycle pulse: IR updated this cycle.
- pc  out  PC_W  current program counter.
- busy  out  1  fetch in progress (state != IDLE).

Function
REQ-003 The FSM SHALL have exactly three states: IDLE, WAIT, DONE.
REQ-004 IDLE, fetch_req=1 and pc_load=0: the next state SHALL be WAIT, with imem_addr=pc registered.
REQ-005 IDLE, fetch_req=1 and pc_load=1 in the same cycle: pc and imem_addr SHALL both take pc_load_val, and the next state SHALL be WAIT.
REQ-006 IDLE, pc_load=1 and fetch_req=0: pc SHALL take pc_load_val next cycle, and the state SHALL remain IDLE.
REQ-007 imem_req SHALL be 1 exactly while in WAIT; imem_addr SHALL be held stable throughout WAIT.
REQ-008 WAIT with imem_ack=1: IR SHALL capture imem_data, pc SHALL take pc+1 modulo 2^PC_W, and the next state SHALL be DONE.
REQ-009 WAIT with imem_ack=0: the block SHALL remain in WAIT indefinitely, with no timeout.
REQ-010 DONE: ir_valid SHALL be 1 for this single cycle, and the next state SHALL be IDLE unconditionally.
REQ-011 Minimum fetch latency SHALL be 3 cycles: request edge -> WAIT; ack edge -> DONE; ir_valid visible in DONE.
REQ-012 fetch_req asserted in WAIT or DONE SHALL be ignored, with no queuing.
REQ-013 pc_load asserted in WAIT or DONE SHALL be captured in a one-entry pending register (flag plus value); a later pc_load overwrites the earlier one.
REQ-014 A pending load SHALL take effect on the transition DONE->IDLE, replacing the increment result, and then clear.
REQ-015 A pending load whose pc_load arrives in the same cycle as imem_ack SHALL be applied at DONE->IDLE in preference to pc+1.
REQ-016 The PC at all-ones SHALL wrap to 0 on increment, with no flag raised.
REQ-017 IR SHALL hold its value between fetches; only REQ-008 writes IR.
REQ-018 imem_ack received outside WAIT SHALL be ignored, with no state, IR or pc change.
REQ-019 busy SHALL equal (state != IDLE), combinationally from the state register.

Reset
REQ-020 On rst_n=0, asynchronously: state=IDLE, pc=RESET_PC, IR=0, ir_valid=0, imem_req=0, imem_addr=RESET_PC, pending load cleared, busy=0.
REQ-021 Reset asserted during WAIT SHALL abort the fetch; an imem_ack arriving after reset release SHALL be ignored per REQ-018.
REQ-022 After rst_n rises, the first rising clk edge SHALL be able to accept fetch_req.

Verification
REQ-023 Basic fetch: reset, fetch_req pulse, imem_ack after 2 wait cycles with data 0xA5 -> IR=0xA5, ir_valid pulses once, pc=0x01, imem_addr=0x00 throughout WAIT.
REQ-024 Wrap: pc_load with 0xFF, fetch, ack with 0x3C -> IR=0x3C, pc=0x00.
REQ-025 Same-cycle load and fetch: IDLE, fetch_req=1, pc_load=1, pc_load_val=0x40 -> imem_addr=0x40; after ack, pc=0x41.
REQ-026 Pending load: in WAIT, pc_load with 0x80, then 0x90; ack -> pc=0x90 in IDLE, not the incremented value; the simultaneous-ack case gives the same result.
REQ-027 Ignored events: fetch_req in WAIT and a stray imem_ack in IDLE -> exactly one ir_valid pulse, IR and pc unchanged by the stray ack.
REQ-028 Mid-fetch reset: rst_n low in WAIT, then a late ack with 0xEE -> IR=0x00, pc=RESET_PC, imem_req=0, no ir_valid pulse.

Source files
------------

// File: rtl/ifetch_unit.sv
// -----------------------------------------------------------------------------
// ifetch_unit
//
// Instruction fetch unit. It owns the program counter and the instruction
// register, and runs one fetch at a time: it issues a request to instruction
// memory, waits as long as needed for the response strobe, captures the
// instruction into IR and advances the PC. A PC load that arrives while a
// fetch is in flight is parked in a one-entry pending register. When the
// fetch completes, that pending load replaces the incremented PC.
//
// Parameters
//   PC_W      program counter / instruction address width
//   INSTR_W   instruction width (matches the control unit IR width)
//   RESET_PC  PC value after reset
//
// Ports
//   clk          in   single clock, rising-edge
//   rst_n        in   asynchronous active-low reset
//   fetch_req    in   request a fetch at the current PC (accepted in IDLE only)
//   pc_load      in   load PC from pc_load_val
//   pc_load_val  in   branch/jump target
//   imem_req     out  instruction-memory request, high exactly while in WAIT
//   imem_addr    out  instruction-memory address, stable throughout WAIT
//   imem_ack     in   memory response-valid strobe (honoured in WAIT only)
//   imem_data    in   memory read data, valid with imem_ack
//   IR           out  instruction register
//   ir_valid     out  one-cycle pulse: IR was updated
//   pc           out  current program counter
//   busy         out  fetch in progress (state != IDLE)
// -----------------------------------------------------------------------------
module ifetch_unit #(
    parameter int PC_W     = 8,
    parameter int INSTR_W  = 8,
    parameter int RESET_PC = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               fetch_req,
    input  logic               pc_load,
    input  logic [PC_W-1:0]    pc_load_val,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [INSTR_W-1:0] IR,
    output logic               ir_valid,
    output logic [PC_W-1:0]    pc,
    output logic               busy
);

    localparam logic [PC_W-1:0] LP_RESET_PC = PC_W'(RESET_PC);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [PC_W-1:0]      r_pc;
    logic [PC_W-1:0]      r_addr;
    logic [INSTR_W-1:0]   r_ir;
    logic                 r_pend;
    logic [PC_W-1:0]      r_pend_val;

    // A pc_load arriving in DONE is folded into the pending entry on the
    // same edge that applies it. A late load therefore still wins at DONE->IDLE.
    logic                 w_pend_flag;
    logic [PC_W-1:0]      w_pend_val;

    assign w_pend_flag = pc_load | r_pend;
    assign w_pend_val  = pc_load ? pc_load_val : r_pend_val;

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM next-state logic
    // -------------------------------------------------------------------------
    // NOTE: w_next gets its default before the case, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (fetch_req) w_next = WAIT;
            WAIT:    if (imem_ack)  w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // PC, fetch address, IR and pending-load registers
    // -------------------------------------------------------------------------
    // NOTE: every register here, including the pending value, is reset. This
    // keeps an aborted fetch from leaving stale or X state behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc       <= LP_RESET_PC;
            r_addr     <= LP_RESET_PC;
            r_ir       <= '0;
            r_pend     <= 1'b0;
            r_pend_val <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (pc_load) begin
                        r_pc <= pc_load_val;
                    end
                    // A same-cycle load redirects the fetch itself.
                    if (fetch_req) begin
                        r_addr <= pc_load ? pc_load_val : r_pc;
                    end
                end
                WAIT: begin
                    if (pc_load) begin
                        r_pend     <= 1'b1;
                        r_pend_val <= pc_load_val;
                    end
                    if (imem_ack) begin
                        r_ir <= imem_data;
                        r_pc <= r_pc + PC_W'(1);
                    end
                end
                DONE: begin
                    if (w_pend_flag) begin
                        r_pc <= w_pend_val;
                    end
                    r_pend <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign imem_req  = (r_state == WAIT);
    assign imem_addr = r_addr;
    assign IR        = r_ir;
    assign ir_valid  = (r_state == DONE);
    assign pc        = r_pc;
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_ifetch_unit.sv
// -----------------------------------------------------------------------------
// tb_ifetch_unit
//
// The driver runs whole fetch transactions. Before driving a transaction it
// works out the expected address, instruction, incremented PC and final PC
// from the fetch rules and pushes them into a scoreboard queue. The monitor
// runs on the falling edge. It checks imem_addr against the queue head while
// a request is open, pops the head on each ir_valid pulse, and then checks
// the PC one cycle later. It also checks that IR holds between fetches.
// -----------------------------------------------------------------------------
module tb_ifetch_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       fetch_req;
    logic       pc_load;
    logic [7:0] pc_load_val;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_ack;
    logic [7:0] imem_data;
    logic [7:0] IR;
    logic       ir_valid;
    logic [7:0] pc;
    logic       busy;

    ifetch_unit #(.PC_W(8), .INSTR_W(8), .RESET_PC(0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fetch_req  (fetch_req),
        .pc_load    (pc_load),
        .pc_load_val(pc_load_val),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_data  (imem_data),
        .IR         (IR),
        .ir_valid   (ir_valid),
        .pc         (pc),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // One fetch transaction, with every optional event in it.
    typedef struct packed {
        bit         pre_ld;     // load in IDLE the cycle before the fetch
        logic [7:0] pre_val;
        bit         same_ld;    // load in the same cycle as fetch_req
        logic [7:0] same_val;
        logic [2:0] n_wait;     // WAIT cycles before the ack (0..4)
        logic [3:0] wait_ld;
        logic [3:0][7:0] wait_val;
        logic [3:0] wait_freq;  // fetch_req pulses that must be ignored
        bit         ack_ld;     // load in the same cycle as imem_ack
        logic [7:0] ack_val;
        logic [7:0] data;
        bit         done_ld;    // load during DONE
        logic [7:0] done_val;
        bit         stray;      // imem_ack in IDLE afterwards
        logic [7:0] stray_data;
    } txn_t;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] ir;
        logic [7:0] pc_inc;
        logic [7:0] pc_after;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] model_pc;
    logic [7:0] exp_ir;
    logic [7:0] pc_exp;
    bit         pc_chk;
    int         n_checks;
    int         n_pass;
    int         n_pulse;
    int         n_txn;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        fetch_req   = 1'b0;
        pc_load     = 1'b0;
        imem_ack    = 1'b0;
        pc_load_val = 8'($urandom);
        imem_data   = 8'($urandom);
    endtask

    // Reference model: the fetch address is the loaded target or the current
    // PC. The final PC is the last load made after the fetch started, or the
    // fetch address plus one, wrapping at 8 bits.
    task automatic run_txn(input txn_t t);
        exp_t       e;
        bit         pend;
        logic [7:0] pv;
        if (t.pre_ld) model_pc = t.pre_val;
        e.addr = t.same_ld ? t.same_val : model_pc;
        pend = 1'b0;
        pv   = '0;
        for (int i = 0; i < int'(t.n_wait); i++)
            if (t.wait_ld[i]) begin pend = 1'b1; pv = t.wait_val[i]; end
        if (t.ack_ld)  begin pend = 1'b1; pv = t.ack_val;  end
        if (t.done_ld) begin pend = 1'b1; pv = t.done_val; end
        e.ir       = t.data;
        e.pc_inc   = 8'((int'(e.addr) + 1) % 256);
        e.pc_after = pend ? pv : e.pc_inc;
        sb.push_back(e);
        n_txn++;
        model_pc = e.pc_after;

        if (t.pre_ld) begin
            pc_load = 1'b1; pc_load_val = t.pre_val;
            cyc(); idle_in();
        end
        fetch_req = 1'b1; pc_load = t.same_ld; pc_load_val = t.same_val;
        cyc(); idle_in();
        for (int i = 0; i < int'(t.n_wait); i++) begin
            fetch_req = t.wait_freq[i]; pc_load = t.wait_ld[i]; pc_load_val = t.wait_val[i];
            cyc(); idle_in();
        end
        imem_ack = 1'b1; imem_data = t.data; pc_load = t.ack_ld; pc_load_val = t.ack_val;
        cyc(); idle_in();
        pc_load = t.done_ld; pc_load_val = t.done_val;
        cyc(); idle_in();
        if (t.stray) begin
            imem_ack = 1'b1; imem_data = t.stray_data;
            cyc(); idle_in();
        end
        cyc();
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (pc_chk) begin
                check("pc_after_fetch", pc, pc_exp);
                pc_chk = 1'b0;
            end
            if (imem_req) begin
                if (sb.size() == 0) check("imem_req_unexpected", imem_req, 0);
                else                check("imem_addr", imem_addr, sb[0].addr);
            end
            if (ir_valid) begin
                n_pulse++;
                if (sb.size() == 0) begin
                    check("ir_valid_unexpected", ir_valid, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    exp_ir = e.ir;
                    check("pc_in_done", pc, e.pc_inc);
                    pc_exp = e.pc_after;
                    pc_chk = 1'b1;
                end
            end
            check("IR", IR, exp_ir);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        txn_t t;
        n_checks = 0; n_pass = 0; n_pulse = 0; n_txn = 0;
        model_pc = 8'h00; exp_ir = 8'h00; pc_chk = 1'b0; pc_exp = '0;
        rst_n = 1'b0;
        idle_in();
        #3;
        check("rst_pc", pc, 8'h00);
        check("rst_ir", IR, 8'h00);
        check("rst_imem_req", imem_req, 0);
        check("rst_imem_addr", imem_addr, 8'h00);
        check("rst_ir_valid", ir_valid, 0);
        check("rst_busy", busy, 0);
        cyc(); cyc();
        rst_n = 1'b1;

        // Basic fetch: two wait cycles, data 0xA5, from PC 0.
        t = '0; t.n_wait = 3'd2; t.data = 8'hA5;
        run_txn(t);
        // Wrap: load 0xFF, fetch, PC goes to 0x00.
        t = '0; t.pre_ld = 1'b1; t.pre_val = 8'hFF; t.n_wait = 3'd1; t.data = 8'h3C;
        run_txn(t);
        // Same-cycle load and fetch.
        t = '0; t.same_ld = 1'b1; t.same_val = 8'h40; t.data = 8'h11;
        run_txn(t);
        // Two pending loads in WAIT: the later one wins.
        t = '0; t.n_wait = 3'd2; t.wait_ld = 4'b0011; t.wait_val[0] = 8'h80;
        t.wait_val[1] = 8'h90; t.data = 8'h22;
        run_txn(t);
        // The second load arrives together with the ack.
        t = '0; t.n_wait = 3'd1; t.wait_ld = 4'b0001; t.wait_val[0] = 8'h80;
        t.ack_ld = 1'b1; t.ack_val = 8'h90; t.data = 8'h33;
        run_txn(t);
        // fetch_req during WAIT and a stray ack in IDLE, both ignored.
        t = '0; t.n_wait = 3'd2; t.wait_freq = 4'b0011; t.data = 8'h44;
        t.stray = 1'b1; t.stray_data = 8'h77;
        run_txn(t);

        // Reset in the middle of WAIT, then a late ack.
        begin
            exp_t e;
            e.addr = model_pc; e.ir = '0; e.pc_inc = '0; e.pc_after = '0;
            sb.push_back(e);
            fetch_req = 1'b1;
            cyc(); idle_in();
            cyc();
            check("busy_in_wait", busy, 1);
            #2;
            rst_n = 1'b0;
            sb.delete();
            exp_ir = 8'h00; model_pc = 8'h00;
            #1;
            check("midrst_imem_req", imem_req, 0);
            check("midrst_pc", pc, 8'h00);
            check("midrst_ir", IR, 8'h00);
            check("midrst_busy", busy, 0);
            cyc();
            rst_n = 1'b1;
            imem_ack = 1'b1; imem_data = 8'hEE;
            cyc(); idle_in();
            #2;
            check("late_ack_ir", IR, 8'h00);
            check("late_ack_pc", pc, 8'h00);
            check("late_ack_req", imem_req, 0);
            check("late_ack_ir_valid", ir_valid, 0);
        end

        // Randomized transactions.
        for (int n = 0; n < 60; n++) begin
            t = '0;
            t.pre_ld     = 1'($urandom_range(0, 1));
            t.pre_val    = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
            t.same_ld    = ($urandom_range(0, 3) == 0);
            t.same_val   = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
            t.n_wait     = 3'($urandom_range(0, 4));
            t.wait_ld    = 4'($urandom) & 4'($urandom);
            for (int i = 0; i < 4; i++) t.wait_val[i] = 8'($urandom);
            t.wait_freq  = 4'($urandom);
            t.ack_ld     = ($urandom_range(0, 3) == 0);
            t.ack_val    = 8'($urandom);
            t.data       = 8'($urandom);
            t.done_ld    = ($urandom_range(0, 3) == 0);
            t.done_val   = 8'($urandom);
            t.stray      = 1'($urandom_range(0, 1));
            t.stray_data = 8'($urandom);
            run_txn(t);
        end

        cyc(); cyc();
        check("scoreboard_empty", sb.size(), 0);
        check("ir_valid_pulses", n_pulse, n_txn);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
